// File: rtl/gpr_file_sb_pkg.sv
// gpr_file_sb_pkg: shared core constants (default register width/address width, hard-wired r0 value)
package gpr_file_sb_pkg;
  localparam int GPR_DATA_W = 32;
  localparam int GPR_ADDR_W = 4;
  localparam logic [31:0] GPR0_CONST = 32'h0000_0000;
endpackage

// File: rtl/gpr_file_sb_scoreboard.sv
// gpr_scoreboard: pending bits (in: clk rst iss_en/iss_addr wb_en/wb_addr flush; out: pending vector, pend_cnt)
module gpr_scoreboard
  import gpr_file_sb_pkg::*;
#(
  parameter int ADDR_W = GPR_ADDR_W
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 iss_en,
  input  logic [ADDR_W-1:0]    iss_addr,
  input  logic                 wb_en,
  input  logic [ADDR_W-1:0]    wb_addr,
  input  logic                 flush,
  output logic [2**ADDR_W-1:0] pending,
  output logic [ADDR_W:0]      pend_cnt
);
  localparam int DEPTH = 2**ADDR_W;
  logic [DEPTH-1:0] set_v, clr_v, nxt;
  logic inc, dec;
  always_comb begin
    set_v = '0;
    clr_v = '0;
    set_v[iss_addr] = iss_en && iss_addr != '0;
    clr_v[wb_addr] = wb_en;
    nxt = ((flush ? '0 : pending & ~clr_v) | set_v) & ~DEPTH'(1);
    inc = set_v[iss_addr] && (flush || !pending[iss_addr]);
    dec = !flush && clr_v[wb_addr] && pending[wb_addr] && !set_v[wb_addr];
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pending <= '0;
      pend_cnt <= '0;
    end else begin
      pending <= nxt;
      pend_cnt <= (flush ? '0 : pend_cnt) + (ADDR_W+1)'(inc) - (ADDR_W+1)'(dec);
    end
  end
endmodule

// File: rtl/gpr_file_sb.sv
// gpr_file_sb: register file, 2 write ports (wa/wb), RD_PORTS bypassed reads (rd_addr->rd_data/rd_busy), pending scoreboard (iss/flush, pend_cnt)
module gpr_file_sb
  import gpr_file_sb_pkg::*;
#(
  parameter int DATA_W   = GPR_DATA_W,
  parameter int ADDR_W   = GPR_ADDR_W,
  parameter int RD_PORTS = 2,
  parameter int BYPASS   = 1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         wa_en,
  input  logic [ADDR_W-1:0]            wa_addr,
  input  logic [DATA_W-1:0]            wa_data,
  input  logic                         wb_en,
  input  logic [ADDR_W-1:0]            wb_addr,
  input  logic [DATA_W-1:0]            wb_data,
  input  logic                         iss_en,
  input  logic [ADDR_W-1:0]            iss_addr,
  input  logic                         flush,
  input  logic [RD_PORTS*ADDR_W-1:0]   rd_addr,
  output logic [RD_PORTS*DATA_W-1:0]   rd_data,
  output logic [RD_PORTS-1:0]          rd_busy,
  output logic [ADDR_W:0]              pend_cnt
);
  localparam int DEPTH = 2**ADDR_W;
  logic [DATA_W-1:0] mem [DEPTH];
  logic [DEPTH-1:0] pending;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < DEPTH; k++) mem[k] <= '0;
    end else begin
      if (wa_en && wa_addr != '0) mem[wa_addr] <= wa_data;
      if (wb_en && wb_addr != '0) mem[wb_addr] <= wb_data;
    end
  end
  gpr_scoreboard #(.ADDR_W(ADDR_W)) u_sb (
    .clk(clk),
    .rst(rst),
    .iss_en(iss_en),
    .iss_addr(iss_addr),
    .wb_en(wb_en),
    .wb_addr(wb_addr),
    .flush(flush),
    .pending(pending),
    .pend_cnt(pend_cnt)
  );
  for (genvar i = 0; i < RD_PORTS; i++) begin : g_rd
    logic [ADDR_W-1:0] a;
    logic wb_hit, wa_hit;
    always_comb begin
      a = rd_addr[i*ADDR_W +: ADDR_W];
      wb_hit = BYPASS != 0 && wb_en && wb_addr == a;
      wa_hit = BYPASS != 0 && wa_en && wa_addr == a;
      rd_data[i*DATA_W +: DATA_W] = a == '0 ? DATA_W'(GPR0_CONST) : wb_hit ? wb_data : wa_hit ? wa_data : mem[a];
      rd_busy[i] = pending[a] && !wb_hit;
    end
  end
endmodule

// File: tb/tb_gpr_file_sb.sv
// tb_gpr_file_sb: directed scoreboard bench for BYPASS=1 and BYPASS=0 instances
module tb_gpr_file_sb;
  logic clk = 0, rst = 1;
  logic wa_en = 0, wb_en = 0, iss_en = 0, flush = 0;
  logic [3:0] wa_addr = 0, wb_addr = 0, iss_addr = 0;
  logic [31:0] wa_data = 0, wb_data = 0;
  logic [7:0] rd_addr = 0;
  logic [63:0] rd_data1, rd_data0;
  logic [1:0] rd_busy1, rd_busy0;
  logic [4:0] pend1, pend0;
  int checks = 0, errors = 0;
  typedef struct {
    string tag;
    int kind;
    int port;
    logic [31:0] val;
  } exp_t;
  exp_t q[$];
  always #5 clk = ~clk;
  gpr_file_sb #(.BYPASS(1)) dut1 (
    .clk(clk), .rst(rst), .wa_en(wa_en), .wa_addr(wa_addr), .wa_data(wa_data),
    .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data), .iss_en(iss_en), .iss_addr(iss_addr),
    .flush(flush), .rd_addr(rd_addr), .rd_data(rd_data1), .rd_busy(rd_busy1), .pend_cnt(pend1)
  );
  gpr_file_sb #(.BYPASS(0)) dut0 (
    .clk(clk), .rst(rst), .wa_en(wa_en), .wa_addr(wa_addr), .wa_data(wa_data),
    .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data), .iss_en(iss_en), .iss_addr(iss_addr),
    .flush(flush), .rd_addr(rd_addr), .rd_data(rd_data0), .rd_busy(rd_busy0), .pend_cnt(pend0)
  );
  function automatic logic [31:0] obs(int k, int p);
    return k == 0 ? rd_data1[p*32 +: 32] : k == 1 ? {31'b0, rd_busy1[p]} : k == 2 ? {27'b0, pend1} :
           k == 3 ? rd_data0[p*32 +: 32] : k == 4 ? {31'b0, rd_busy0[p]} : {27'b0, pend0};
  endfunction
  task automatic ex(string t, int k, int p, logic [31:0] v);
    q.push_back('{t, k, p, v});
  endtask
  task automatic drain();
    while (q.size() > 0) begin
      exp_t e;
      logic [31:0] o;
      e = q.pop_front();
      o = obs(e.kind, e.port);
      checks++;
      assert (o === e.val) else begin
        errors++;
        $error("FAIL %s observed=%h expected=%h", e.tag, o, e.val);
      end
    end
  endtask
  task automatic rd(logic [3:0] a0, logic [3:0] a1);
    rd_addr = {a1, a0};
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
    wa_en = 0; wb_en = 0; iss_en = 0; flush = 0;
    #1;
  endtask
  initial begin
    rd(0, 1);
    #2;
    ex("rst_r0_b1", 0, 0, 0); ex("rst_r1_b1", 0, 1, 0); ex("rst_busy_b1", 1, 0, 0);
    ex("rst_pend_b1", 2, 0, 0); ex("rst_r1_b0", 3, 1, 0); ex("rst_pend_b0", 5, 0, 0);
    drain();
    #10 rst = 0;
    @(posedge clk); #1;
    // r0 writes are discarded
    wa_en = 1; wa_addr = 0; wa_data = 32'hDEADBEEF; rd(0, 0); #1;
    ex("r0_same", 0, 0, 0); drain();
    tick();
    ex("r0_after_b1", 0, 0, 0); ex("r0_after_b0", 3, 0, 0); drain();
    // wa bypass to port 1
    wa_en = 1; wa_addr = 5; wa_data = 32'h12345678; rd(0, 5); #1;
    ex("wa_byp_b1", 0, 1, 32'h12345678); ex("wa_byp_b0", 3, 1, 0); drain();
    tick();
    ex("wa_next_b1", 0, 1, 32'h12345678); ex("wa_next_b0", 3, 1, 32'h12345678); drain();
    // dual write same address: wb wins
    wa_en = 1; wa_addr = 7; wa_data = 32'h1111; wb_en = 1; wb_addr = 7; wb_data = 32'h2222; rd(7, 5); #1;
    ex("dual_byp_b1", 0, 0, 32'h2222); ex("dual_byp_b0", 3, 0, 0); drain();
    tick();
    ex("dual_next_b1", 0, 0, 32'h2222); ex("dual_next_b0", 3, 0, 32'h2222); drain();
    // issue r3 then r9
    iss_en = 1; iss_addr = 3; rd(3, 9); #1;
    ex("iss_same_busy", 1, 0, 0); drain();
    tick();
    iss_en = 1; iss_addr = 9;
    tick();
    ex("busy_r3", 1, 0, 1); ex("busy_r9", 1, 1, 1); ex("pend2_b1", 2, 0, 2); ex("pend2_b0", 5, 0, 2); drain();
    // wb r3 clears busy same cycle with bypass
    wb_en = 1; wb_addr = 3; wb_data = 32'hCAFE; #1;
    ex("wb_busy_b1", 1, 0, 0); ex("wb_data_b1", 0, 0, 32'hCAFE); ex("wb_busy_b0", 4, 0, 1);
    ex("wb_data_b0", 3, 0, 0); ex("wb_pend_same", 2, 0, 2); drain();
    tick();
    ex("wb_pend_next", 2, 0, 1); ex("wb_busy_b0_next", 4, 0, 0); ex("r9_still", 1, 1, 1);
    ex("r3_b0", 3, 0, 32'hCAFE); drain();
    // iss and wb to r4 together: issue wins
    iss_en = 1; iss_addr = 4; wb_en = 1; wb_addr = 4; wb_data = 32'h4444; rd(4, 9);
    tick();
    ex("iswb_busy", 1, 0, 1); ex("iswb_pend", 2, 0, 2); ex("iswb_data", 3, 0, 32'h4444); drain();
    iss_en = 1; iss_addr = 4;
    tick();
    ex("reiss_pend", 2, 0, 2); drain();
    wb_en = 1; wb_addr = 6; wb_data = 32'h6666;
    tick();
    ex("wb_nonpend", 2, 0, 2); ex("wb_nonpend_b0", 5, 0, 2); drain();
    iss_en = 1; iss_addr = 0;
    tick();
    ex("iss_r0", 2, 0, 2); drain();
    iss_en = 1; iss_addr = 11;
    tick();
    ex("pend3", 2, 0, 3); drain();
    // flush with issue r2 and wb r9
    flush = 1; iss_en = 1; iss_addr = 2; wb_en = 1; wb_addr = 9; wb_data = 32'h9999; rd(2, 9);
    tick();
    ex("fl_pend", 2, 0, 1); ex("fl_pend_b0", 5, 0, 1); ex("fl_r2", 1, 0, 1); ex("fl_r9", 1, 1, 0);
    ex("fl_wb_data", 3, 1, 32'h9999); drain();
    rd(11, 4); #1;
    ex("fl_r11", 1, 0, 0); ex("fl_r4", 1, 1, 0); drain();
    // async reset mid-cycle discards a write in flight
    wa_en = 1; wa_addr = 8; wa_data = 32'h8888; rd(5, 8); #2;
    rst = 1; #1;
    ex("ar_pend", 2, 0, 0); ex("ar_r5", 0, 0, 0); ex("ar_r5_b0", 3, 0, 0); ex("ar_r8_b0", 3, 1, 0); drain();
    rd(2, 8);
    @(posedge clk); #1;
    wa_en = 0; #1;
    ex("ar_busy_r2", 1, 0, 0);
    ex("ar_r8", 0, 1, 0);
    drain();
    rst = 0;
    tick();
    ex("post_rst_r8", 0, 1, 0); ex("post_rst_pend", 2, 0, 0); drain();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
